// File: rtl/vc_ctrl_pkg.sv
// Shared definitions for the VC dispatch controller: state encodings and
// the traffic-class select bit helper.
package vc_ctrl_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    // The top data bit carries the traffic class and selects VC1 when set.
    function automatic int vc_sel_bit(input int bw);
        return bw - 1;
    endfunction

endpackage

// File: rtl/vc_router.sv
// Steers a word popped from the Main FIFO to VC0 or VC1 according to its
// traffic-class bit; data is held at zero when no word is being delivered.
module vc_router
    import vc_ctrl_pkg::*;
#(
    parameter int BW = 6
) (
    input  logic          valid,
    input  logic [BW-1:0] data_in,
    output logic          vc0_wr,
    output logic          vc1_wr,
    output logic [BW-1:0] data_out
);

    localparam int SEL = vc_sel_bit(BW);

    assign vc1_wr   = valid &  data_in[SEL];
    assign vc0_wr   = valid & ~data_in[SEL];
    assign data_out = valid ? data_in : '0;

endmodule

// File: rtl/vc_dispatch_ctrl.sv
// Sequencer between the Main FIFO and the two VC FIFOs: programs thresholds,
// pops Main and routes each word by traffic class, latches FIFO errors.
// Optional per-VC write counters are built when VC_STATS_EN is defined.
module vc_dispatch_ctrl #(
    parameter int BW      = 6,
    parameter int LEN4    = 4,
    parameter int STATE_W = 3
) (
    input  logic               clk,
    input  logic               reset_L,
    input  logic               init,
    input  logic [LEN4-1:0]    umbral_MF_cfg_low,
    input  logic [LEN4-1:0]    umbral_MF_cfg_high,
    input  logic [LEN4-1:0]    umbral_VC_cfg_low,
    input  logic [LEN4-1:0]    umbral_VC_cfg_high,
    input  logic               Main_empty,
    input  logic               Main_error,
    input  logic [BW-1:0]      Main_data_in,
    input  logic               VC0_almost_full,
    input  logic               VC1_almost_full,
    input  logic               VC0_error,
    input  logic               VC1_error,
    output logic               Main_rd,
    output logic               VC0_wr,
    output logic               VC1_wr,
    output logic [BW-1:0]      VC_data_out,
    output logic [LEN4-1:0]    UmbralMF_LOW,
    output logic [LEN4-1:0]    UmbralMF_HIGH,
    output logic [LEN4-1:0]    UmbralVC_LOW,
    output logic [LEN4-1:0]    UmbralVC_HIGH,
    output logic [STATE_W-1:0] state,
    output logic               idle_out,
    output logic               error_out
`ifdef VC_STATS_EN
    ,
    output logic [7:0]         vc0_count,
    output logic [7:0]         vc1_count
`endif
);

    import vc_ctrl_pkg::*;

    state_t          state_reg, state_next;
    logic            rd_d1_reg;
    logic            error_reg;
    logic [LEN4-1:0] mf_low_reg, mf_high_reg, vc_low_reg, vc_high_reg;
    logic            err_any;
    logic            main_rd;
    logic            deliver;

    assign err_any = Main_error | VC0_error | VC1_error;
    assign main_rd = (state_reg == ST_ACTIVE) & ~Main_empty
                   & ~VC0_almost_full & ~VC1_almost_full;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RESET:  state_next = ST_INIT;
            ST_INIT: begin
                if (err_any)     state_next = ST_ERROR;
                else if (!init)  state_next = ST_IDLE;
            end
            ST_IDLE: begin
                if (err_any)          state_next = ST_ERROR;
                else if (init)        state_next = ST_INIT;
                else if (!Main_empty) state_next = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                // init is deliberately not looked at until the burst drains
                if (err_any)
                    state_next = ST_ERROR;
                else if (Main_empty && !main_rd && !rd_d1_reg)
                    state_next = ST_IDLE;
            end
            ST_ERROR:  state_next = ST_ERROR;
            default:   state_next = ST_RESET;
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_reg   <= ST_RESET;
            rd_d1_reg   <= 1'b0;
            error_reg   <= 1'b0;
            mf_low_reg  <= '0;
            mf_high_reg <= '0;
            vc_low_reg  <= '0;
            vc_high_reg <= '0;
        end else begin
            state_reg <= state_next;
            rd_d1_reg <= main_rd;
            if (state_next == ST_ERROR)
                error_reg <= 1'b1;
            if (state_reg == ST_INIT) begin
                mf_low_reg  <= umbral_MF_cfg_low;
                mf_high_reg <= umbral_MF_cfg_high;
                vc_low_reg  <= umbral_VC_cfg_low;
                vc_high_reg <= umbral_VC_cfg_high;
            end
        end
    end

    // A word popped just before an error is discarded rather than written.
    assign deliver = rd_d1_reg & (state_reg != ST_ERROR);

    vc_router #(
        .BW(BW)
    ) u_router (
        .valid    (deliver),
        .data_in  (Main_data_in),
        .vc0_wr   (VC0_wr),
        .vc1_wr   (VC1_wr),
        .data_out (VC_data_out)
    );

    assign Main_rd       = main_rd;
    assign UmbralMF_LOW  = mf_low_reg;
    assign UmbralMF_HIGH = mf_high_reg;
    assign UmbralVC_LOW  = vc_low_reg;
    assign UmbralVC_HIGH = vc_high_reg;
    assign state         = STATE_W'(state_reg);
    assign idle_out      = (state_reg == ST_IDLE);
    assign error_out     = error_reg;

`ifdef VC_STATS_EN
    logic [1:0] vc_wr_vec;
    logic [7:0] vc_count_reg [2];

    assign vc_wr_vec = {VC1_wr, VC0_wr};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_vc_stats
            always_ff @(posedge clk or negedge reset_L) begin
                if (!reset_L)
                    vc_count_reg[gi] <= '0;
                else if (state_next == ST_INIT)
                    vc_count_reg[gi] <= '0;
                else if (vc_wr_vec[gi])
                    vc_count_reg[gi] <= vc_count_reg[gi] + 8'd1;
            end
        end
    endgenerate

    assign vc0_count = vc_count_reg[0];
    assign vc1_count = vc_count_reg[1];
`endif

endmodule

// File: tb/tb_vc_dispatch_ctrl.sv
// Directed self-checking bench for vc_dispatch_ctrl; the Main FIFO is
// emulated by driving Main_empty / Main_data_in step by step.
module tb_vc_dispatch_ctrl;

    localparam int BW      = 6;
    localparam int LEN4    = 4;
    localparam int STATE_W = 3;

    logic               clk = 1'b0;
    logic               reset_L;
    logic               init;
    logic [LEN4-1:0]    umbral_MF_cfg_low, umbral_MF_cfg_high;
    logic [LEN4-1:0]    umbral_VC_cfg_low, umbral_VC_cfg_high;
    logic               Main_empty, Main_error;
    logic [BW-1:0]      Main_data_in;
    logic               VC0_almost_full, VC1_almost_full;
    logic               VC0_error, VC1_error;
    logic               Main_rd, VC0_wr, VC1_wr;
    logic [BW-1:0]      VC_data_out;
    logic [LEN4-1:0]    UmbralMF_LOW, UmbralMF_HIGH, UmbralVC_LOW, UmbralVC_HIGH;
    logic [STATE_W-1:0] state;
    logic               idle_out, error_out;
`ifdef VC_STATS_EN
    logic [7:0]         vc0_count, vc1_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vc_dispatch_ctrl #(
        .BW(BW), .LEN4(LEN4), .STATE_W(STATE_W)
    ) dut (
        .clk                (clk),
        .reset_L            (reset_L),
        .init               (init),
        .umbral_MF_cfg_low  (umbral_MF_cfg_low),
        .umbral_MF_cfg_high (umbral_MF_cfg_high),
        .umbral_VC_cfg_low  (umbral_VC_cfg_low),
        .umbral_VC_cfg_high (umbral_VC_cfg_high),
        .Main_empty         (Main_empty),
        .Main_error         (Main_error),
        .Main_data_in       (Main_data_in),
        .VC0_almost_full    (VC0_almost_full),
        .VC1_almost_full    (VC1_almost_full),
        .VC0_error          (VC0_error),
        .VC1_error          (VC1_error),
        .Main_rd            (Main_rd),
        .VC0_wr             (VC0_wr),
        .VC1_wr             (VC1_wr),
        .VC_data_out        (VC_data_out),
        .UmbralMF_LOW       (UmbralMF_LOW),
        .UmbralMF_HIGH      (UmbralMF_HIGH),
        .UmbralVC_LOW       (UmbralVC_LOW),
        .UmbralVC_HIGH      (UmbralVC_HIGH),
        .state              (state),
        .idle_out           (idle_out),
        .error_out          (error_out)
`ifdef VC_STATS_EN
        ,
        .vc0_count          (vc0_count),
        .vc1_count          (vc1_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Read port and both write strobes plus the routed data in one go.
    task automatic check_io(input string tag, input logic rd, input logic w0,
                            input logic w1, input logic [BW-1:0] data);
        check({tag, ".rd"},   32'(Main_rd),     32'(rd));
        check({tag, ".vc0"},  32'(VC0_wr),      32'(w0));
        check({tag, ".vc1"},  32'(VC1_wr),      32'(w1));
        check({tag, ".data"}, 32'(VC_data_out), 32'(data));
        $display("step %-12s rd=%0b vc0=%0b vc1=%0b data=%02h state=%0d",
                 tag, Main_rd, VC0_wr, VC1_wr, VC_data_out, state);
    endtask

    task automatic check_thr(input string tag, input logic [15:0] exp);
        check(tag, 32'({UmbralMF_LOW, UmbralMF_HIGH, UmbralVC_LOW, UmbralVC_HIGH}), 32'(exp));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [BW-1:0] burst [5];

    initial begin
        burst = '{6'h21, 6'h01, 6'h22, 6'h02, 6'h23};
        reset_L = 1'b0; init = 1'b0;
        umbral_MF_cfg_low = 4'd2; umbral_MF_cfg_high = 4'd14;
        umbral_VC_cfg_low = 4'd1; umbral_VC_cfg_high = 4'd3;
        Main_empty = 1'b1; Main_error = 1'b0; Main_data_in = '0;
        VC0_almost_full = 1'b0; VC1_almost_full = 1'b0;
        VC0_error = 1'b0; VC1_error = 1'b0;

        // Reset values
        #2;
        check("rst.state", 32'(state), 32'd0);
        check_thr("rst.thr", 16'h0000);
        check("rst.idle", 32'(idle_out), 32'd0);
        check("rst.err", 32'(error_out), 32'd0);
        check_io("rst", 1'b0, 1'b0, 1'b0, 6'h00);

        // Threshold programming
        reset_L = 1'b1; init = 1'b1;
        tick();
        check("init.state", 32'(state), 32'd1);
        check_thr("init.thr0", 16'h0000);
        tick();
        check("init.state2", 32'(state), 32'd1);
        check_thr("init.thr", 16'h2E13);
        init = 1'b0;
        tick();
        check("idle.state", 32'(state), 32'd2);
        check("idle.idle", 32'(idle_out), 32'd1);
        check_thr("idle.thr", 16'h2E13);

        // Two words, VC1 then VC0
        Main_empty = 1'b0; #1;
        check_io("t2.idle", 1'b0, 1'b0, 1'b0, 6'h00);
        tick();
        check("t2.act", 32'(state), 32'd3);
        check_io("t2.pop0", 1'b1, 1'b0, 1'b0, 6'h00);
        tick();
        Main_data_in = 6'h25; #1;
        check_io("t2.w25", 1'b1, 1'b0, 1'b1, 6'h25);
        tick();
        Main_data_in = 6'h05; Main_empty = 1'b1; #1;
        check_io("t2.w05", 1'b0, 1'b1, 1'b0, 6'h05);
        tick();
        check("t2.drain", 32'(state), 32'd3);
        check_io("t2.drain", 1'b0, 1'b0, 1'b0, 6'h00);
        tick();
        check("t2.back", 32'(state), 32'd2);

        // Back-pressure from VC0
        Main_empty = 1'b0;
        tick();
        check_io("t3.pop0", 1'b1, 1'b0, 1'b0, 6'h00);
        tick();
        Main_data_in = 6'h21; VC0_almost_full = 1'b1; #1;
        check_io("t3.stall1", 1'b0, 1'b0, 1'b1, 6'h21);
        tick();
        check_io("t3.stall2", 1'b0, 1'b0, 1'b0, 6'h00);
        tick();
        check_io("t3.stall3", 1'b0, 1'b0, 1'b0, 6'h00);
        tick();
        VC0_almost_full = 1'b0; #1;
        check_io("t3.resume", 1'b1, 1'b0, 1'b0, 6'h00);
        tick();
        Main_data_in = 6'h02; #1;
        check_io("t3.w02", 1'b1, 1'b1, 1'b0, 6'h02);
        tick();
        Main_data_in = 6'h23; Main_empty = 1'b1; #1;
        check_io("t3.w23", 1'b0, 1'b0, 1'b1, 6'h23);
        tick();
        tick();
        check("t3.back", 32'(state), 32'd2);

        // Error while a pop is in flight
        Main_empty = 1'b0;
        tick();
        check_io("t4.pop0", 1'b1, 1'b0, 1'b0, 6'h00);
        tick();
        Main_data_in = 6'h11; Main_error = 1'b1; #1;
        check_io("t4.w11", 1'b1, 1'b1, 1'b0, 6'h11);
        tick();
        Main_error = 1'b0; Main_data_in = 6'h12; #1;
        check("t4.state", 32'(state), 32'd4);
        check("t4.err", 32'(error_out), 32'd1);
        check_io("t4.drop", 1'b0, 1'b0, 1'b0, 6'h00);
        init = 1'b1;
        tick();
        check("t4.stuck", 32'(state), 32'd4);
        check("t4.sticky", 32'(error_out), 32'd1);
        check_io("t4.quiet", 1'b0, 1'b0, 1'b0, 6'h00);
        Main_empty = 1'b1;

        // Recover through reset, new thresholds
        reset_L = 1'b0; #1;
        check("t5.rst.err", 32'(error_out), 32'd0);
        check("t5.rst.state", 32'(state), 32'd0);
        umbral_MF_cfg_low = 4'd3; umbral_MF_cfg_high = 4'd12;
        umbral_VC_cfg_low = 4'd2; umbral_VC_cfg_high = 4'd5;
        reset_L = 1'b1;
        tick();
        tick();
        init = 1'b0;
        tick();
        check("t5.idle", 32'(state), 32'd2);
        check_thr("t5.thr", 16'h3C25);

        // Five-word burst: three to VC1, two to VC0
        Main_empty = 1'b0;
        tick();
        check_io("t5.pop0", 1'b1, 1'b0, 1'b0, 6'h00);
        for (int k = 0; k < 5; k++) begin
            tick();
            Main_data_in = burst[k];
            if (k == 4) Main_empty = 1'b1;
            #1;
            check_io("t5.burst", (k < 4), ~burst[k][BW-1], burst[k][BW-1], burst[k]);
        end
        tick();
        tick();
        check("t5.back", 32'(state), 32'd2);
`ifdef VC_STATS_EN
        check("st.vc1", 32'(vc1_count), 32'd3);
        check("st.vc0", 32'(vc0_count), 32'd2);
`endif
        init = 1'b1;
        tick();
        check("t5.reinit", 32'(state), 32'd1);
`ifdef VC_STATS_EN
        check("st.clr1", 32'(vc1_count), 32'd0);
        check("st.clr0", 32'(vc0_count), 32'd0);
`endif
        init = 1'b0;
        tick();

        // Asynchronous reset in the middle of a burst
        Main_empty = 1'b0;
        tick();
        tick();
        Main_data_in = 6'h30; #1;
        check_io("t6.w30", 1'b1, 1'b0, 1'b1, 6'h30);
        #1;
        reset_L = 1'b0;
        #1;
        check_io("t6.async", 1'b0, 1'b0, 1'b0, 6'h00);
        check("t6.state", 32'(state), 32'd0);
        check_thr("t6.thr", 16'h0000);
        check("t6.idle", 32'(idle_out), 32'd0);
        check("t6.err", 32'(error_out), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vc_dispatch_ctrl.md
Name: vc_dispatch_ctrl

Overview:
Controller that sequences the Main FIFO.
- Programs its almost-full/almost-empty thresholds and the VC FIFO thresholds.
- Pops words from Main and steers each word to VC0 or VC1 by its traffic-class bit, honouring VC back-pressure.
- Latches FIFO errors.
- Sits between the Main FIFO instance and the two VC FIFO instances in the QoS path.

Parameters:
BW, 6, data word width; bit BW-1 is the TC/VC select bit.
LEN4, 4, threshold width (matches FIFO address width).
STATE_W, 3, width of the one-hot-free encoded state output.

Ports:
clk  in  1  single clock, rising edge.
reset_L  in  1  asynchronous active-low reset.
init  in  1  request to (re)enter INIT and load thresholds.
umbral_MF_cfg_low  in  LEN4  Main FIFO low threshold to program.
umbral_MF_cfg_high  in  LEN4  Main FIFO high threshold to program.
umbral_VC_cfg_low  in  LEN4  VC FIFOs low threshold to program.
umbral_VC_cfg_high  in  LEN4  VC FIFOs high threshold to program.
Main_empty  in  1  Main FIFO empty.
Main_error  in  1  Main FIFO error_output.
Main_data_in  in  BW  Main FIFO data out (valid the cycle after Main_rd).
VC0_almost_full  in  1  VC0 FIFO almost full.
VC1_almost_full  in  1  VC1 FIFO almost full.
VC0_error  in  1  VC0 FIFO error.
VC1_error  in  1  VC1 FIFO error.
Main_rd  out  1  pop Main FIFO.
VC0_wr  out  1  push VC0 FIFO.
VC1_wr  out  1  push VC1 FIFO.
VC_data_out  out  BW  data to both VC FIFOs.
UmbralMF_LOW  out  LEN4  registered Main low threshold.
UmbralMF_HIGH  out  LEN4  registered Main high threshold.
UmbralVC_LOW  out  LEN4  registered VC low threshold.
UmbralVC_HIGH  out  LEN4  registered VC high threshold.
state  out  STATE_W  current state code.
idle_out  out  1  high in IDLE.
error_out  out  1  sticky error flag.

Behaviour:
- States and codes: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4.
- Reset (async, reset_L=0):
  - state=RESET.
  - All thresholds, Main_rd, VC0_wr, VC1_wr, VC_data_out, idle_out, error_out = 0.
  - In-flight flag rd_d1 = 0.
- RESET: first clock edge with reset_L=1 → INIT.
- INIT: threshold registers load cfg inputs every cycle. init=0 → IDLE.
- IDLE: idle_out=1. init=1 → INIT; else !Main_empty → ACTIVE.
- ACTIVE:
  - Main_rd (combinational) = ACTIVE & !Main_empty & !VC0_almost_full & !VC1_almost_full.
  - rd_d1 registers Main_rd.
  - With rd_d1=1: VC_data_out = Main_data_in (combinational), VC1_wr = Main_data_in[BW-1], VC0_wr = !Main_data_in[BW-1].
  - Transition to IDLE when Main_empty & !Main_rd & !rd_d1.
  - init in ACTIVE is ignored until IDLE is reached.
- Error handling:
  - Any of Main_error, VC0_error, VC1_error = 1 in INIT, IDLE or ACTIVE → ERROR next edge; error_out=1 from that edge.
  - In ERROR, Main_rd, VC0_wr and VC1_wr are forced to 0, and any word with rd_d1 pending is dropped.
  - ERROR exits only through reset.
- Back-pressure: an almost_full on either VC stalls all pops; a word already popped is always written (one-word slack is guaranteed by the almost-full margin).
- Throughput: one word per cycle when unstalled. Latency Main_rd→VCx_wr is 1 cycle.
- Thresholds hold their values outside INIT.
- Simultaneous init & error: error wins.

Optional Feature:
VC_STATS_EN:
- Defined:
  - Adds outputs vc0_count and vc1_count, 8 bits each.
  - Each increments on VC0_wr or VC1_wr respectively, wrapping 255→0.
  - Both clear on reset and on entry to INIT.
- Undefined: the ports and counters are absent.

Decomposition:
- Package vc_ctrl_pkg: state encodings (ST_RESET … ST_ERROR), STATE_W, and the VC select bit index function.
- Sub-module vc_router: the combinational steering of rd_d1/data into VC0_wr, VC1_wr and VC_data_out. Instantiated once.

Test Plan:
- Reset then init=1 for 2 cycles with cfg MF 2/14 and VC 1/3, then init=0 → thresholds read 2/14/1/3; state goes INIT→IDLE; idle_out=1.
- Main holds 0x25 and 0x05 (BW=6) → state goes to ACTIVE; Main_rd on 2 consecutive cycles; VC1_wr with data 0x25, then VC0_wr with data 0x05, one cycle after each pop; state returns to IDLE.
- VC0_almost_full=1 for 3 cycles while Main is non-empty → Main_rd=0 for those cycles; the in-flight word is still written; popping resumes the cycle after deassertion.
- Main_error pulse in ACTIVE with a pop pending → state=ERROR next edge; no VCx_wr afterwards; error_out stays 1 until reset_L=0.
- reset_L low mid-burst → all outputs 0 immediately (asynchronous); thresholds become 0.
- With VC_STATS_EN defined, 3 words to VC1 and 2 to VC0 → vc1_count=3, vc0_count=2; re-entering INIT clears both.
